// File: rtl/if_pkg.sv
// if_pkg: shared widths and constants for the fetch stage
package if_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] END_MARKER = 32'h0;
  localparam int DEFAULT_IMEM_DEPTH = 128;
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: redirect, instruction-memory and decode handshake bundle of the fetch stage
interface if_fetch_if;
  import if_pkg::*;
  logic redirect;
  logic [XLEN-1:0] redirect_pc;
  logic id_ready;
  logic [XLEN-1:0] im_addr;
  logic [XLEN-1:0] im_dout;
  logic if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic halted;
  modport master(
    input redirect, redirect_pc, id_ready, im_dout,
    output im_addr, if_valid, if_instr, if_pc, halted
  );
  modport slave(
    output redirect, redirect_pc, id_ready, im_dout,
    input im_addr, if_valid, if_instr, if_pc, halted
  );
endinterface

// File: rtl/if_fifo.sv
// if_fifo: 2-entry instruction/pc FIFO with flush, head shown combinationally
module if_fifo
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din_instr,
  input  logic [XLEN-1:0] din_pc,
  output logic            valid,
  output logic            full,
  output logic [XLEN-1:0] dout_instr,
  output logic [XLEN-1:0] dout_pc
);
  logic [XLEN-1:0] instr_q [2];
  logic [XLEN-1:0] pc_q [2];
  logic rd, wr;
  logic [1:0] cnt;
  assign valid = cnt != 2'd0;
  assign full = cnt[1];
  assign dout_instr = instr_q[rd];
  assign dout_pc = pc_q[rd];
  // storage and pointers; flush drops contents but leaves stale data in place
  always_ff @(posedge clk)
    if (rst) begin
      instr_q <= '{default: '0};
      pc_q <= '{default: '0};
      rd <= 1'b0;
      wr <= 1'b0;
      cnt <= 2'd0;
    end else if (flush) begin
      rd <= 1'b0;
      wr <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        instr_q[wr] <= din_instr;
        pc_q[wr] <= din_pc;
        wr <= ~wr;
      end
      if (pop) rd <= ~rd;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC sequencing, end-marker/range halt, redirect flush; IF_BUF_EN selects a 2-entry output FIFO
module if_fetch
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
  input logic clk,
  input logic rst,
  if_fetch_if.master b
);
  localparam logic [XLEN-1:0] DEPTH = XLEN'(IMEM_DEPTH);
  logic [XLEN-1:0] pc;
  logic halted, take, free, try_fetch, stop, fetch;
  assign take = b.if_valid & b.id_ready;
  assign try_fetch = ~halted & ~b.redirect & free;
  assign stop = b.im_dout == END_MARKER || pc >= DEPTH;
  assign fetch = try_fetch & ~stop;
  assign b.im_addr = pc;
  assign b.halted = halted;
  // pc and halt flag: reset beats redirect, a blocked fetch attempt halts with pc held
  always_ff @(posedge clk)
    if (rst) begin
      pc <= RESET_PC;
      halted <= 1'b0;
    end else if (b.redirect) begin
      pc <= b.redirect_pc;
      halted <= 1'b0;
    end else if (fetch) pc <= pc + 1'b1;
    else if (try_fetch) halted <= 1'b1;
`ifdef IF_BUF_EN
  logic full;
  assign free = ~full | take;
  if_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(b.redirect),
    .push(fetch),
    .pop(take),
    .din_instr(b.im_dout),
    .din_pc(pc),
    .valid(b.if_valid),
    .full(full),
    .dout_instr(b.if_instr),
    .dout_pc(b.if_pc)
  );
`else
  assign free = ~b.if_valid | b.id_ready;
  // single output register: load on fetch, empty on consume or redirect
  always_ff @(posedge clk)
    if (rst) begin
      b.if_valid <= 1'b0;
      b.if_instr <= '0;
      b.if_pc <= '0;
    end else if (b.redirect) b.if_valid <= 1'b0;
    else if (fetch) begin
      b.if_valid <= 1'b1;
      b.if_instr <= b.im_dout;
      b.if_pc <= pc;
    end else if (take) b.if_valid <= 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: table vectors, directed corner sequences and random traffic against a queue model
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'd0;
  localparam int DEPTH = 128;
`ifdef IF_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  typedef struct packed {logic [31:0] instr, pc;} ent_t;
  typedef struct {
    logic r, rd, rdy;
    logic [31:0] rpc;
    logic v;
    logic [31:0] pc, instr, addr;
    logic h;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem [256];
  int checks = 0;
  int failures = 0;
  ent_t q[$];
  logic [31:0] m_pc;
  bit m_halt;
  vec_t tv[7];

  if_fetch_if bus();
  if_fetch #(.RESET_PC(RESET_PC), .IMEM_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .b(bus));
  assign bus.im_dout = mem[bus.im_addr[7:0]];

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic void model_step();
    bit take;
    int room;
    logic [31:0] w;
    if (rst) begin
      q.delete();
      m_pc = RESET_PC;
      m_halt = 0;
    end else if (bus.redirect) begin
      q.delete();
      m_pc = bus.redirect_pc;
      m_halt = 0;
    end else begin
      take = q.size() > 0 && bus.id_ready;
      room = CAP - q.size() + (take ? 1 : 0);
      if (take) void'(q.pop_front());
      if (!m_halt && room > 0) begin
        w = mem[m_pc[7:0]];
        if (m_pc >= DEPTH || w == 32'h0) m_halt = 1;
        else begin
          q.push_back({w, m_pc});
          m_pc = m_pc + 1;
        end
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("m_valid", {31'b0, bus.if_valid}, {31'b0, q.size() > 0});
    chk("m_addr", bus.im_addr, m_pc);
    chk("m_halted", {31'b0, bus.halted}, {31'b0, m_halt});
    if (q.size() > 0) begin
      chk("m_if_pc", bus.if_pc, q[0].pc);
      chk("m_if_instr", bus.if_instr, q[0].instr);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    rst = r;
    bus.redirect = rd;
    bus.redirect_pc = rpc;
    bus.id_ready = rdy;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h00100193;
    mem[1] = 32'h00000213;
    mem[2] = 32'h00219293;
    mem[3] = 32'h0;
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    tv[0] = '{1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'h0, 32'd0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd0, 32'h00100193, 32'd1, 1'b0};
    tv[2] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd1, 32'h00000213, 32'd2, 1'b0};
    tv[3] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd2, 32'h00219293, 32'd3, 1'b0};
    tv[4] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'h0, 32'd3, 1'b1};
    tv[5] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 32'h0, 32'd0, 1'b0};
    tv[6] = '{1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'd0, 32'h00100193, 32'd1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(tv[i].r, tv[i].rd, tv[i].rpc, tv[i].rdy);
      cycle();
      chk($sformatf("t%0d_valid", i), {31'b0, bus.if_valid}, {31'b0, tv[i].v});
      chk($sformatf("t%0d_addr", i), bus.im_addr, tv[i].addr);
      chk($sformatf("t%0d_halted", i), {31'b0, bus.halted}, {31'b0, tv[i].h});
      if (tv[i].v || tv[i].r) begin
        chk($sformatf("t%0d_if_pc", i), bus.if_pc, tv[i].pc);
        chk($sformatf("t%0d_if_instr", i), bus.if_instr, tv[i].instr);
      end
    end
    mem[3] = 32'h13;
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_if_pc", bus.if_pc, 32'd0);
      chk("stall_if_instr", bus.if_instr, 32'h00100193);
    end
    chk("stall_addr", bus.im_addr, 32'(CAP));
    drive(1'b0, 1'b1, 32'd9, 1'b1);
    cycle();
    chk("redir_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("redir_addr", bus.im_addr, 32'd9);
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    cycle();
    chk("redir_if_pc", bus.if_pc, 32'd9);
    chk("redir_valid2", {31'b0, bus.if_valid}, 32'd1);
    drive(1'b0, 1'b1, 32'd126, 1'b1);
    cycle();
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("oob_no128", {31'b0, bus.if_valid && bus.if_pc == 32'd128}, 32'd0);
    end
    chk("oob_halted", {31'b0, bus.halted}, 32'd1);
    chk("oob_addr", bus.im_addr, 32'd128);
    drive(1'b0, 1'b1, 32'd0, 1'b0);
    cycle();
    chk("oob_unhalt", {31'b0, bus.halted}, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    drive(1'b1, 1'b1, 32'd50, 1'b0);
    cycle();
    chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_addr", bus.im_addr, RESET_PC);
    chk("rst_halted", {31'b0, bus.halted}, 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'd0);
    for (int i = 0; i < 256; i++) mem[i] = ($urandom % 20 == 0) ? 32'h0 : ($urandom | 32'h1);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom % 64 == 0, $urandom % 12 == 0, 32'($urandom_range(0, 140)), $urandom % 4 != 0);
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 0: word-index PC loaded at reset.
REQ-002 SHALL have parameter IMEM_DEPTH, default 128: number of valid instruction words.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port redirect  in  1  branch/jump taken; load redirect_pc.
REQ-007 SHALL have port redirect_pc  in  32  word-index target PC.
REQ-008 SHALL have port id_ready  in  1  decode accepts if_instr this cycle.
REQ-009 SHALL have port im_addr  out  32  word address to instruction memory, equal to the PC register.
REQ-010 SHALL have port im_dout  in  32  combinational instruction word read from im_addr.
REQ-011 SHALL have port if_valid  out  1  if_instr/if_pc hold a valid instruction.
REQ-012 SHALL have port if_instr  out  32  fetched instruction.
REQ-013 SHALL have port if_pc  out  32  word PC of if_instr.
REQ-014 SHALL have port halted  out  1  fetch stopped on end marker or out-of-range PC.

Function
REQ-015 PC SHALL be word-indexed; the sequential next PC SHALL be pc+1, modulo 2^32.
REQ-016 A fetch SHALL occur in a cycle when halted=0, redirect=0 and the output store has a free slot or id_ready=1 with if_valid=1.
REQ-017 On a fetch, im_dout and pc SHALL be written to the output store and pc SHALL advance to pc+1 at the same edge; fetch-to-if_valid latency SHALL be 1 cycle.
REQ-018 Handshake: an instruction SHALL be consumed on an edge where if_valid=1 and id_ready=1; if_instr/if_pc SHALL stay stable while if_valid=1 and id_ready=0.
REQ-019 Sustained throughput with id_ready held at 1 SHALL be 1 instruction/cycle.
REQ-020 If im_dout==32'h0 (end marker), the word SHALL NOT be enqueued, pc SHALL hold, and halted SHALL be set at the next edge.
REQ-021 If pc >= IMEM_DEPTH, the fetch SHALL NOT enqueue, and halted SHALL be set at the next edge.
REQ-022 While halted=1, already-enqueued instructions SHALL still drain via the handshake.
REQ-023 redirect=1 SHALL have top priority: pc<=redirect_pc, output store flushed (if_valid<=0), halted<=0, and no fetch that cycle; the first post-redirect instruction SHALL appear 2 cycles after the redirect edge... precisely: fetched in cycle N+1, if_valid=1 in cycle N+2.
REQ-024 redirect together with id_ready SHALL drop the current output; no instruction is consumed twice.

Reset
REQ-025 While rst=1 at a clock edge: pc<=RESET_PC, if_valid<=0, store emptied, halted<=0, if_instr<=0, if_pc<=0.
REQ-026 rst SHALL override redirect and any fetch in the same cycle; reset mid-stall SHALL discard buffered instructions.

Configuration
REQ-027 Macro IF_BUF_EN defined: output store SHALL be a 2-entry FIFO; fetch continues while fewer than 2 entries are held, even if id_ready=0; if_instr/if_pc SHALL present the head entry.
REQ-028 IF_BUF_EN undefined: output store SHALL be a single register; fetch SHALL occur only when the register is empty or is being consumed in the same cycle.

Structure
REQ-029 Shared package if_pkg SHALL hold XLEN=32, END_MARKER=32'h0 and DEFAULT_IMEM_DEPTH=128.
REQ-030 The 2-entry buffer SHALL be a sub-module if_fifo, with flush input, instantiated only under IF_BUF_EN.

Verification
REQ-031 Reset then id_ready=1, imem words 0..3 = 0x00100193,0x00000213,0x00219293,0 -> if_pc 0,1,2 in consecutive cycles, then halted=1 with pc=3, if_valid=0.
REQ-032 id_ready=0 for 3 cycles with words nonzero -> if_instr/if_pc stable; pc advances by 1 (no buffer) or 2 (IF_BUF_EN) and then holds.
REQ-033 redirect=1, redirect_pc=9 while if_valid=1 -> next cycle if_valid=0, im_addr=9; following cycle if_pc=9.
REQ-034 pc reaches 128 with IMEM_DEPTH=128 -> halted=1, no instruction with if_pc=128 emitted; redirect to 0 clears halted.
REQ-035 rst=1 asserted with 2 entries buffered and redirect=1 -> next cycle if_valid=0, im_addr=RESET_PC, halted=0.
